div_iter_unit: RTL and testbench

//  Multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU. It replaces the

---
 rtl/div_iter_unit.sv | 149 ++++++++++++++
 tb/tb_div_iter_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/div_iter_unit.sv
// Multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit is produced per cycle; sign correction happens in a single fixup cycle.
module div_iter_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a_in,
    input  logic [XLEN-1:0] b_in,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] c_out
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST_STEP = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ITER  = 2'd1;
    localparam logic [1:0] S_FIXUP = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN:0]   pr_q, pr_d;      // partial remainder, already shifted by the next dividend bit
    logic [XLEN-1:0] quo_q, quo_d;    // dividend bits leave the top, quotient bits enter the bottom
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic            is_rem_q, is_rem_d;
    logic            q_neg_q, q_neg_d;
    logic            r_neg_q, r_neg_d;
    logic [XLEN-1:0] c_out_q, c_out_d;

    logic            op_valid, is_signed_op, is_rem_op;
    logic            a_neg, b_neg, accept, div_zero, overflow;
    logic [XLEN-1:0] a_abs, b_abs;
    logic [XLEN:0]   diff;
    logic            trial_neg;
    logic [XLEN-1:0] keep, rem_mag, fix_quo, fix_rem;

    always_comb begin
        op_valid     = funct3[2];
        is_signed_op = ~funct3[0];
        is_rem_op    = funct3[1];
        a_neg        = is_signed_op & a_in[XLEN-1];
        b_neg        = is_signed_op & b_in[XLEN-1];
        a_abs        = a_neg ? -a_in : a_in;
        b_abs        = b_neg ? -b_in : b_in;
        div_zero     = (b_in == '0);
        overflow     = is_signed_op && (a_in == MIN_NEG) && (b_in == '1);
        accept       = start && op_valid && !flush && (state_q == S_IDLE || state_q == S_DONE);

        diff      = pr_q - {1'b0, dvs_q};
        trial_neg = diff[XLEN];
        keep      = trial_neg ? pr_q[XLEN-1:0] : diff[XLEN-1:0];

        // The final step shifts in a zero pad bit, so the true remainder sits one bit up.
        rem_mag = pr_q[XLEN:1];
        fix_quo = q_neg_q ? -quo_q : quo_q;
        fix_rem = r_neg_q ? -rem_mag : rem_mag;
    end

    always_comb begin
        // NOTE: every _d starts from its _q so no path through this block can infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        pr_d     = pr_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        is_rem_d = is_rem_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        c_out_d  = c_out_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (accept) begin
                    is_rem_d = is_rem_op;
                    q_neg_d  = a_neg ^ b_neg;
                    r_neg_d  = a_neg;
                    dvs_d    = b_abs;
                    if (div_zero) begin
                        c_out_d = is_rem_op ? a_in : '1;
                        state_d = S_DONE;
                    end else if (overflow) begin
                        c_out_d = is_rem_op ? '0 : MIN_NEG;
                        state_d = S_DONE;
                    end else begin
                        cnt_d   = '0;
                        pr_d    = {{XLEN{1'b0}}, a_abs[XLEN-1]};
                        quo_d   = {a_abs[XLEN-2:0], 1'b0};
                        state_d = S_ITER;
                    end
                end
            end
            S_ITER: begin
                pr_d  = {keep, quo_q[XLEN-1]};
                quo_d = {quo_q[XLEN-2:0], ~trial_neg};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_STEP) begin
                    state_d = S_FIXUP;
                end
            end
            S_FIXUP: begin
                c_out_d = is_rem_q ? fix_rem : fix_quo;
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        if (flush) begin
            state_d = S_IDLE;
            c_out_d = c_out_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            pr_q     <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            is_rem_q <= 1'b0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            c_out_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pr_q     <= pr_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            is_rem_q <= is_rem_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            c_out_q  <= c_out_d;
        end
    end

    assign busy  = (state_q == S_ITER) || (state_q == S_FIXUP);
    assign done  = (state_q == S_DONE);
    assign c_out = c_out_q;

endmodule

// File: tb/tb_div_iter_unit.sv
// Self-checking bench for div_iter_unit: an arithmetic reference model checked every cycle,
// plus directed vectors with hand-computed results and latencies.
module tb_div_iter_unit;

    localparam logic [2:0] F_DIV  = 3'b100;
    localparam logic [2:0] F_DIVU = 3'b101;
    localparam logic [2:0] F_REM  = 3'b110;
    localparam logic [2:0] F_REMU = 3'b111;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] a_in = '0;
    logic [31:0] b_in = '0;
    logic        flush = 1'b0;
    logic        busy, done;
    logic [31:0] c_out;

    int checks = 0;
    int failures = 0;
    bit mon_en = 1'b0;

    div_iter_unit #(.XLEN(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct3 (funct3),
        .a_in   (a_in),
        .b_in   (b_in),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .c_out  (c_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference result straight from the RISC-V M-extension rules.
    function automatic logic [31:0] ref_div(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = 0;
        case (f3)
            F_DIV:  r = (b == 0) ? -1 : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? sa : sa / sb;
            F_REM:  r = (b == 0) ? sa : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 0 : sa % sb;
            F_DIVU: r = (b == 0) ? -1 : longint'(a) / longint'(b);
            F_REMU: r = (b == 0) ? longint'(a) : longint'(a) % longint'(b);
            default: r = 0;
        endcase
        return r[31:0];
    endfunction

    function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (b == 0) return 1;
        if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    // Model: an accepted op completes after its latency; c_out takes the result when done rises.
    bit          m_active = 1'b0;
    int          m_left = 0;
    logic [31:0] m_res = '0;
    logic [31:0] m_c = '0;

    always @(posedge clk) begin
        bit free;
        if (rst) begin
            m_active = 1'b0;
            m_left   = 0;
            m_c      = '0;
        end else if (flush) begin
            m_active = 1'b0;
            m_left   = 0;
        end else begin
            free = !m_active || (m_left == 0);
            if (start && funct3[2] && free) begin
                m_active = 1'b1;
                m_left   = ref_lat(funct3, a_in, b_in) - 1;
                m_res    = ref_div(funct3, a_in, b_in);
            end else if (m_active) begin
                if (m_left == 0) m_active = 1'b0;
                else m_left--;
            end
            if (m_active && m_left == 0) m_c = m_res;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            check("busy", {31'b0, busy}, {31'b0, m_active && m_left != 0});
            check("done", {31'b0, done}, {31'b0, m_active && m_left == 0});
            check("c_out", c_out, m_c);
        end
    end

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 100);
    endtask

    task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_c, input int exp_lat);
        int n;
        @(negedge clk);
        start = 1'b1; funct3 = f3; a_in = a; b_in = b;
        @(posedge clk);
        #1;
        start = 1'b0; a_in = ~a; b_in = b + 32'd1;
        wait_done(n);
        check({name, " latency"}, 32'(n), 32'(exp_lat));
        check({name, " result"}, c_out, exp_c);
    endtask

    initial begin
        int n;
        int pulses;

        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;
        rst    = 1'b0;
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset done", {31'b0, done}, 32'd0);
        check("reset c_out", c_out, 32'd0);

        run_op("DIV 100/7",     F_DIV,  32'd100,       32'd7,         32'd14,        34);
        run_op("REM 100/7",     F_REM,  32'd100,       32'd7,         32'd2,         34);
        run_op("DIV -100/7",    F_DIV,  32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 34);
        run_op("REM -100/7",    F_REM,  32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFFE, 34);
        // (2^32 - 100) mod 7 = (4 - 2) mod 7 = 2
        run_op("REMU big/7",    F_REMU, 32'hFFFF_FF9C, 32'd7,         32'd2,         34);
        run_op("DIVU 5/0",      F_DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
        run_op("REMU 5/0",      F_REMU, 32'd5,         32'd0,         32'd5,         1);
        run_op("DIV ovf",       F_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("REM ovf",       F_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);
        run_op("DIV 7/-2",      F_DIV,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 34);
        run_op("REM 7/-2",      F_REM,  32'd7,         32'hFFFF_FFFE, 32'd1,         34);
        run_op("DIVU min/-1",   F_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         34);
        run_op("DIV -7/0",      F_DIV,  32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, 1);
        run_op("REM -7/0",      F_REM,  32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 1);
        run_op("DIVU max/1",    F_DIVU, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 34);

        // An invalid funct3 must not start anything.
        @(negedge clk);
        start = 1'b1; funct3 = 3'b000; a_in = 32'd50; b_in = 32'd5;
        @(negedge clk);
        start = 1'b0;
        check("bad funct3 busy", {31'b0, busy}, 32'd0);
        check("bad funct3 c_out", c_out, 32'hFFFF_FFFF);

        // Flush 10 cycles into an operation.
        @(negedge clk);
        start = 1'b1; funct3 = F_DIVU; a_in = 32'd1000; b_in = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush busy", {31'b0, busy}, 32'd0);
        check("flush c_out", c_out, 32'hFFFF_FFFF);
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("flush no done", 32'(pulses), 32'd0);
        run_op("DIVU 9/3", F_DIVU, 32'd9, 32'd3, 32'd3, 34);

        // Back-to-back: start held through op A's DONE cycle carries op B in.
        @(negedge clk);
        start = 1'b1; funct3 = F_DIV; a_in = 32'd100; b_in = 32'd7;
        @(posedge clk);
        #1;
        funct3 = F_DIVU; a_in = 32'd1000; b_in = 32'd10;
        wait_done(n);
        check("b2b A latency", 32'(n), 32'd34);
        check("b2b A result", c_out, 32'd14);
        @(posedge clk);
        #1;
        start = 1'b0; a_in = '0; b_in = '0;
        wait_done(n);
        check("b2b B latency", 32'(n), 32'd34);
        check("b2b B result", c_out, 32'd100);

        // Reset in the middle of an operation.
        @(negedge clk);
        start = 1'b1; funct3 = F_DIV; a_in = 32'd100; b_in = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst busy", {31'b0, busy}, 32'd0);
        check("rst done", {31'b0, done}, 32'd0);
        check("rst c_out", c_out, 32'd0);
        repeat (40) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
